pb_command_sequencer: RTL and testbench
=======================================

Name: pb_command_sequencer

Overview:
- Sits between the UART command parser and the peripheral-bus command state machines (write4, read4, adc4, adc1, test).
- Accepts one decoded command at a time and drives exactly one sub-machine activation line. It waits for that sub-machine's completion, latches its response bytes, then streams a framed response to the UART TX path.
- Guarantees mutual exclusion on the shared board bus. No two sub-machines are ever active together.

Parameters:
- CLOCK_FREQUENCY, 27000000, system clock in Hz.
- TIMEOUT_US, 1000, completion watchdog in microseconds; TIMEOUT_CYCLES = CLOCK_FREQUENCY/1000000*TIMEOUT_US.
- ERR_BYTE, 8'hEE, response byte sent for a rejected or failed command.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered by the parser.
- cmd_ready  out  1  sequencer can accept; transfer occurs when cmd_valid && cmd_ready.
- cmd_opcode  in  3  0=WRITE4, 1=READ4, 2=ADC4, 3=ADC1, 4=TEST, 5..7 invalid.
- cmd_params  in  32  four parameter bytes; byte0 in [7:0].
- param_data  out  32  registered copy of cmd_params, stable while any active line is high.
- sub_active  out  5  one-hot activation; bit index = opcode.
- sub_complete  in  5  completion from each sub-machine.
- resp_bytes  in  32  response bytes from the sub-machines; byte0 in [7:0].
- resp_count  in  4  number of valid response bytes.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- tx_ready  in  1  UART TX accepts tx_data when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag; set on watchdog expiry, cleared when the next command is accepted.

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 in IDLE after reset; sub_active=0, param_data=0, tx_valid=0, tx_data=0, busy=0, timeout_err=0. The state register returns to IDLE.
- States: IDLE, LAUNCH, WAIT_DONE, LATCH, TX_HDR, TX_BODY, TX_ERR.
- IDLE: cmd_ready=1. On a handshake, register opcode and params and go to LAUNCH. If opcode>4, go to TX_ERR instead.
- LAUNCH: drive sub_active[opcode]=1 (one cycle after acceptance), clear the watchdog, go to WAIT_DONE.
- WAIT_DONE: hold sub_active. When sub_complete[opcode] is sampled high, go to LATCH. sub_complete bits for other opcodes are ignored.
- LATCH:
  - drop sub_active to 0 in the same edge;
  - capture resp_bytes;
  - capture min(resp_count,4) as the byte count;
  - go to TX_HDR.
- TX_HDR: tx_valid=1, tx_data={5'b0,opcode}. Advance on tx_ready to TX_BODY, or to IDLE if count=0.
- TX_BODY: send bytes 0..count-1 in order, one per tx handshake. After the last byte, return to IDLE.
- TX_ERR: send a single ERR_BYTE, then return to IDLE.
- tx_valid and tx_data stay stable until accepted. tx_ready with tx_valid=0 has no effect.
- Latency: acceptance to sub_active high = 2 edges. Complete to first tx_valid = 2 edges.
- Only one command is in flight at a time. cmd_ready=0 in every non-IDLE state.
- Asserting reset mid-operation forces sub_active=0 immediately (asynchronous). Any partially sent frame is abandoned.
- resp_count>4 is clamped to 4. Only resp_bytes[31:0] are sent.
- sub_complete already high on the LAUNCH edge counts only once WAIT_DONE is entered.

Optional Feature:
- PB_CMD_TIMEOUT_EN: when defined, a counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: drop sub_active, set timeout_err, go to TX_ERR.
  - The resulting frame is ERR_BYTE only; no header is sent.
- When undefined: no counter; WAIT_DONE waits indefinitely, and timeout_err is tied 0.

Decomposition:
- Shared package pb_cmd_pkg holds:
  - the opcode enum (PB_OP_WRITE4..PB_OP_TEST);
  - the sequencer state enum;
  - ERR_BYTE default;
  - the response header format.
- The command parser and the sub-machines import the same opcode enum.
- One natural sub-module: pb_resp_serializer. It takes the latched bytes, count and header, and drives the tx_valid/tx_ready handshake.

Test Plan:
- READ4 with params 0x11223344, complete after 10 cycles with resp_bytes=0xDDCCBBAA and count=4 -> sub_active=5'b00010 for exactly the wait window; tx stream 0x01,0xAA,0xBB,0xCC,0xDD; busy falls after 0xDD.
- WRITE4, complete with count=0 -> tx stream is the single byte 0x00; cmd_ready returns 1 on the next cycle.
- Invalid opcode 6 -> sub_active never set; single byte 0xEE; timeout_err stays 0.
- ADC1 with tx_ready toggled 1-in-3 and resp_count=7 -> tx_data held stable while stalled; exactly 4 body bytes sent.
- With PB_CMD_TIMEOUT_EN and TIMEOUT_US=1 at 27 MHz, TEST never completes -> sub_active drops after 27 cycles in WAIT_DONE; 0xEE sent; timeout_err=1 until the next accepted command.
- Reset pulsed low during WAIT_DONE of ADC4 -> sub_active=0 asynchronously; no tx_valid after release; the next command runs normally.

Source files
------------

// File: rtl/pb_cmd_pkg.sv
// Shared opcode, sequencer state and response-frame definitions for the
// peripheral-bus command path (parser, sequencer and sub-machines).
package pb_cmd_pkg;

    typedef enum logic [2:0] {
        PB_OP_WRITE4 = 3'd0,
        PB_OP_READ4  = 3'd1,
        PB_OP_ADC4   = 3'd2,
        PB_OP_ADC1   = 3'd3,
        PB_OP_TEST   = 3'd4
    } pb_opcode_e;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_LAUNCH    = 3'd1,
        SEQ_WAIT_DONE = 3'd2,
        SEQ_LATCH     = 3'd3,
        SEQ_TX_HDR    = 3'd4,
        SEQ_TX_BODY   = 3'd5,
        SEQ_TX_ERR    = 3'd6
    } pb_seq_state_e;

    localparam int         PB_NUM_SUBS         = 5;
    localparam int         PB_MAX_RESP_BYTES   = 4;
    localparam logic [7:0] PB_ERR_BYTE_DEFAULT = 8'hEE;

    // Header byte leading every non-error response frame.
    typedef struct packed {
        logic [4:0] reserved;
        logic [2:0] opcode;
    } pb_resp_hdr_t;

    function automatic logic [7:0] pb_resp_header(input logic [2:0] opcode);
        pb_resp_hdr_t hdr;
        hdr.reserved = '0;
        hdr.opcode   = opcode;
        return hdr;
    endfunction

    function automatic logic pb_opcode_valid(input logic [2:0] opcode);
        return opcode <= PB_OP_TEST;
    endfunction

    function automatic logic [PB_NUM_SUBS-1:0] pb_onehot(input logic [2:0] opcode);
        logic [PB_NUM_SUBS-1:0] line;
        line = '0;
        case (opcode)
            PB_OP_WRITE4: line = 5'b00001;
            PB_OP_READ4:  line = 5'b00010;
            PB_OP_ADC4:   line = 5'b00100;
            PB_OP_ADC1:   line = 5'b01000;
            PB_OP_TEST:   line = 5'b10000;
            default:      line = '0;
        endcase
        return line;
    endfunction

    function automatic logic [2:0] pb_clamp_count(input logic [3:0] count);
        return (count > 4'd4) ? 3'd4 : count[2:0];
    endfunction

endpackage

// File: rtl/pb_resp_serializer.sv
// Streams one response frame (header + up to four body bytes, or a lone
// error byte) over a valid/ready byte handshake with registered outputs.
module pb_resp_serializer
    import pb_cmd_pkg::*;
#(
    parameter logic [7:0] ERR_BYTE = PB_ERR_BYTE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        start_err,
    input  logic [7:0]  header,
    input  logic [31:0] bytes,
    input  logic [2:0]  count,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_fire,
    output logic        frame_done
);

    logic [1:0] idx;
    logic       last;
    logic [7:0] body_byte;

    assign tx_fire    = tx_valid && tx_ready;
    assign frame_done = tx_fire && last;

    always_comb begin
        body_byte = bytes[7:0];
        case (idx)
            2'd0: body_byte = bytes[7:0];
            2'd1: body_byte = bytes[15:8];
            2'd2: body_byte = bytes[23:16];
            2'd3: body_byte = bytes[31:24];
            default: body_byte = bytes[7:0];
        endcase
    end

    // 'last' marks that the byte currently on tx_data ends the frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            idx      <= 2'd0;
            last     <= 1'b0;
        end else if (start) begin
            tx_valid <= 1'b1;
            tx_data  <= header;
            idx      <= 2'd0;
            last     <= (count == 3'd0);
        end else if (start_err) begin
            tx_valid <= 1'b1;
            tx_data  <= ERR_BYTE;
            idx      <= 2'd0;
            last     <= 1'b1;
        end else if (tx_fire) begin
            if (last) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= body_byte;
                idx     <= idx + 2'd1;
                last    <= (({1'b0, idx} + 3'd1) == count);
            end
        end
    end

endmodule

// File: rtl/pb_command_sequencer.sv
// Single-command sequencer arbitrating the shared board bus between the
// peripheral sub-machines. Optional watchdog: define PB_CMD_TIMEOUT_EN.
module pb_command_sequencer
    import pb_cmd_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 27000000,
    parameter int         TIMEOUT_US      = 1000,
    parameter logic [7:0] ERR_BYTE        = PB_ERR_BYTE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_opcode,
    input  logic [31:0]            cmd_params,
    output logic [31:0]            param_data,
    output logic [PB_NUM_SUBS-1:0] sub_active,
    input  logic [PB_NUM_SUBS-1:0] sub_complete,
    input  logic [31:0]            resp_bytes,
    input  logic [3:0]             resp_count,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    pb_seq_state_e state;
    logic [2:0]    opcode_q;
    logic [31:0]   resp_q;
    logic [2:0]    count_q;

    logic cmd_accept;
    logic complete_hit;
    logic timeout_hit;
    logic ser_start;
    logic ser_start_err;
    logic tx_fire;
    logic frame_done;

    assign cmd_accept   = (state == SEQ_IDLE) && cmd_valid && cmd_ready;
    // Only the completion line of the launched sub-machine matters.
    assign complete_hit = (state == SEQ_WAIT_DONE) && |(sub_complete & pb_onehot(opcode_q));
    assign ser_start     = (state == SEQ_LATCH);
    assign ser_start_err = (cmd_accept && !pb_opcode_valid(cmd_opcode)) || timeout_hit;

`ifdef PB_CMD_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;

    assign timeout_hit = (state == SEQ_WAIT_DONE) && !complete_hit && (wd_count == WD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_count <= '0;
        end else if (state == SEQ_LAUNCH) begin
            wd_count <= '0;
        end else if (state == SEQ_WAIT_DONE) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (cmd_accept) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= SEQ_IDLE;
            opcode_q   <= 3'd0;
            param_data <= 32'h0;
            sub_active <= '0;
            resp_q     <= 32'h0;
            count_q    <= 3'd0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_accept) begin
                        opcode_q   <= cmd_opcode;
                        param_data <= cmd_params;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= pb_opcode_valid(cmd_opcode) ? SEQ_LAUNCH : SEQ_TX_ERR;
                    end
                end
                SEQ_LAUNCH: begin
                    sub_active <= pb_onehot(opcode_q);
                    state      <= SEQ_WAIT_DONE;
                end
                SEQ_WAIT_DONE: begin
                    if (complete_hit) begin
                        sub_active <= '0;
                        resp_q     <= resp_bytes;
                        count_q    <= pb_clamp_count(resp_count);
                        state      <= SEQ_LATCH;
                    end else if (timeout_hit) begin
                        sub_active <= '0;
                        state      <= SEQ_TX_ERR;
                    end
                end
                SEQ_LATCH: begin
                    state <= SEQ_TX_HDR;
                end
                SEQ_TX_HDR: begin
                    if (tx_fire) begin
                        if (count_q == 3'd0) begin
                            state     <= SEQ_IDLE;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            state <= SEQ_TX_BODY;
                        end
                    end
                end
                SEQ_TX_BODY, SEQ_TX_ERR: begin
                    if (frame_done) begin
                        state     <= SEQ_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= SEQ_IDLE;
                    sub_active <= '0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b0;
                end
            endcase
        end
    end

    pb_resp_serializer #(
        .ERR_BYTE(ERR_BYTE)
    ) u_serializer (
        .clock      (clock),
        .reset      (reset),
        .start      (ser_start),
        .start_err  (ser_start_err),
        .header     (pb_resp_header(opcode_q)),
        .bytes      (resp_q),
        .count      (count_q),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_fire    (tx_fire),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_pb_command_sequencer.sv
// Directed self-checking bench for pb_command_sequencer; the watchdog case
// runs only when PB_CMD_TIMEOUT_EN is defined.
module tb_pb_command_sequencer;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_params;
    logic [31:0] param_data;
    logic [4:0]  sub_active;
    logic [4:0]  sub_complete;
    logic [31:0] resp_bytes;
    logic [3:0]  resp_count;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        timeout_err;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [7:0] tx_log[$];
    logic [7:0] exp_frame[$];
    logic [4:0] active_seen;
    logic       stall_mode;
    int         stall_phase;
    logic       prev_stall;
    logic [7:0] prev_data;
    int         high_cycles;

    pb_command_sequencer #(
        .CLOCK_FREQUENCY(27000000),
        .TIMEOUT_US     (1),
        .ERR_BYTE       (8'hEE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_params  (cmd_params),
        .param_data  (param_data),
        .sub_active  (sub_active),
        .sub_complete(sub_complete),
        .resp_bytes  (resp_bytes),
        .resp_count  (resp_count),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] params);
        for (int n = 0; n < 50 && !cmd_ready; n++) tick();
        checkOutput("cmd_ready_before_issue", 32'(cmd_ready), 32'h1);
        tx_log.delete();
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_params = params;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        for (int n = 0; n < limit && busy; n++) tick();
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'h0);
        checkOutput({tag, "_ready_back"}, 32'(cmd_ready), 32'h1);
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_frame_len"}, 32'(tx_log.size()), 32'(exp_frame.size()));
        for (int i = 0; i < exp_frame.size() && i < tx_log.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(tx_log[i]), 32'(exp_frame[i]));
    endtask

    // tx_ready is refreshed just after each rising edge; 1-in-3 when stalling.
    always @(posedge clock) begin
        #1;
        if (stall_mode) begin
            stall_phase = (stall_phase == 2) ? 0 : stall_phase + 1;
            tx_ready    = (stall_phase == 0);
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Byte log, hold-while-stalled and one-hot checks, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("tx_hold_valid", 32'(tx_valid), 32'h1);
                checkOutput("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) tx_log.push_back(tx_data);
            prev_stall  = tx_valid && !tx_ready;
            prev_data   = tx_data;
            active_seen = active_seen | sub_active;
            if (sub_active != 5'b0)
                checkOutput("sub_active_onehot", 32'($countones(sub_active)), 32'h1);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit: got expired, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_opcode   = 3'd0;
        cmd_params   = 32'h0;
        sub_complete = 5'b0;
        resp_bytes   = 32'h0;
        resp_count   = 4'd0;
        tx_ready     = 1'b1;
        stall_mode   = 1'b0;
        stall_phase  = 0;
        prev_stall   = 1'b0;
        prev_data    = 8'h00;
        active_seen  = 5'b0;

        repeat (3) tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("rst_sub_active", 32'(sub_active), 32'h0);
        checkOutput("rst_param_data", param_data, 32'h0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'h1);

        // READ4: ten-cycle wait, stray WRITE4 completion mid-way is ignored.
        applyStimulus(3'd1, 32'h11223344);
        checkOutput("read4_launch_gap", 32'(sub_active), 32'h0);
        checkOutput("read4_busy", 32'(busy), 32'h1);
        checkOutput("read4_ready_low", 32'(cmd_ready), 32'h0);
        tick();
        checkOutput("read4_active", 32'(sub_active), 32'h02);
        checkOutput("read4_params", param_data, 32'h11223344);
        high_cycles = 1;
        for (int i = 0; i < 9; i++) begin
            sub_complete = (i == 4) ? 5'b00001 : 5'b00000;
            resp_bytes   = 32'hFFFFFFFF;
            tick();
            if (sub_active == 5'b00010) high_cycles++;
        end
        sub_complete = 5'b00010;
        resp_bytes   = 32'hDDCCBBAA;
        resp_count   = 4'd4;
        tick();
        sub_complete = 5'b0;
        checkOutput("read4_window", 32'(high_cycles), 32'd10);
        checkOutput("read4_active_drop", 32'(sub_active), 32'h0);
        checkOutput("read4_no_tx_yet", 32'(tx_valid), 32'h0);
        tick();
        checkOutput("read4_hdr_valid", 32'(tx_valid), 32'h1);
        checkOutput("read4_hdr_data", 32'(tx_data), 32'h01);
        waitIdle("read4", 50);
        exp_frame = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        checkFrame("read4");

        // WRITE4 with an empty response: header only.
        applyStimulus(3'd0, 32'hA5A5A5A5);
        tick();
        checkOutput("write4_active", 32'(sub_active), 32'h01);
        checkOutput("write4_params", param_data, 32'hA5A5A5A5);
        sub_complete = 5'b00001;
        resp_count   = 4'd0;
        tick();
        sub_complete = 5'b0;
        tick();
        checkOutput("write4_hdr_data", 32'(tx_data), 32'h00);
        tick();
        checkOutput("write4_ready_next", 32'(cmd_ready), 32'h1);
        waitIdle("write4", 20);
        exp_frame = '{8'h00};
        checkFrame("write4");

        // Invalid opcode 6: error byte only, no activation.
        active_seen = 5'b0;
        applyStimulus(3'd6, 32'h0);
        checkOutput("inv_err_valid", 32'(tx_valid), 32'h1);
        checkOutput("inv_err_data", 32'(tx_data), 32'hEE);
        waitIdle("inv", 20);
        checkOutput("inv_no_active", 32'(active_seen), 32'h0);
        checkOutput("inv_timeout_err", 32'(timeout_err), 32'h0);
        exp_frame = '{8'hEE};
        checkFrame("inv");

        // ADC1 with 1-in-3 tx_ready and an over-long count.
        stall_mode = 1'b1;
        applyStimulus(3'd3, 32'h0000_0007);
        tick();
        checkOutput("adc1_active", 32'(sub_active), 32'h08);
        sub_complete = 5'b01000;
        resp_bytes   = 32'h44332211;
        resp_count   = 4'd7;
        tick();
        sub_complete = 5'b0;
        waitIdle("adc1", 200);
        exp_frame = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        checkFrame("adc1");
        stall_mode = 1'b0;
        tick();

        // Reset pulse while ADC4 waits.
        applyStimulus(3'd2, 32'h12345678);
        tick();
        checkOutput("adc4_active", 32'(sub_active), 32'h04);
        repeat (3) tick();
        reset = 1'b0;
        #2;
        checkOutput("adc4_async_drop", 32'(sub_active), 32'h0);
        checkOutput("adc4_rst_busy", 32'(busy), 32'h0);
        checkOutput("adc4_rst_ready", 32'(cmd_ready), 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tx_log.delete();
        repeat (5) tick();
        checkOutput("adc4_no_tx_after", 32'(tx_log.size()), 32'h0);
        checkOutput("adc4_ready_after", 32'(cmd_ready), 32'h1);

        // Normal TEST command after the reset.
        applyStimulus(3'd4, 32'hCAFEF00D);
        tick();
        checkOutput("test_active", 32'(sub_active), 32'h10);
        checkOutput("test_params", param_data, 32'hCAFEF00D);
        sub_complete = 5'b10000;
        resp_bytes   = 32'h0000BEEF;
        resp_count   = 4'd2;
        tick();
        sub_complete = 5'b0;
        waitIdle("test", 50);
        exp_frame = '{8'h04, 8'hEF, 8'hBE};
        checkFrame("test");

`ifdef PB_CMD_TIMEOUT_EN
        // TEST never completes: 27-cycle watchdog at 27 MHz / 1 us.
        applyStimulus(3'd4, 32'h0);
        tick();
        high_cycles = 0;
        for (int n = 0; n < 100 && sub_active != 5'b0; n++) begin
            high_cycles++;
            tick();
        end
        checkOutput("wd_window", 32'(high_cycles), 32'd27);
        checkOutput("wd_err_valid", 32'(tx_valid), 32'h1);
        checkOutput("wd_err_data", 32'(tx_data), 32'hEE);
        checkOutput("wd_flag_set", 32'(timeout_err), 32'h1);
        waitIdle("wd", 20);
        exp_frame = '{8'hEE};
        checkFrame("wd");
        repeat (2) tick();
        checkOutput("wd_flag_sticky", 32'(timeout_err), 32'h1);
        applyStimulus(3'd0, 32'h1);
        checkOutput("wd_flag_cleared", 32'(timeout_err), 32'h0);
        tick();
        sub_complete = 5'b00001;
        resp_count   = 4'd0;
        tick();
        sub_complete = 5'b0;
        waitIdle("wd_next", 20);
        exp_frame = '{8'h00};
        checkFrame("wd_next");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
